// File: rtl/accumulator_sequencer.sv
// Accumulator control stage driving a 16x8 register file over a shared 8-bit bus.
// Each instruction takes an accept cycle in FETCH plus one EXEC or WRITE cycle.
module accumulator_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [3:0] rf_read_addr,
  output logic       rf_read_en,
  output logic [3:0] rf_write_addr,
  output logic       rf_write_en,
  inout  wire  [7:0] bus,
  output logic [7:0] acc,
  output logic       carry,
  output logic       zero,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_MOV = 4'h3,
    OP_LD  = 4'h4,
    OP_AND = 4'h5,
    OP_XOR = 4'h6,
    OP_LDI = 4'h7,
    OP_HLT = 4'hF
  } op_t;

  state_t     state, state_next;
  logic [7:0] ir;
  logic [3:0] op;
  logic       read_req, write_req, bus_drive;
  logic [8:0] sum, diff;
  logic [7:0] acc_next;
  logic       carry_next, zero_next;

  assign op = ir[7:4];

  // Next-state and raw control decode
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    read_req    = 1'b0;
    write_req   = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (instr[7:4] == OP_MOV)      state_next = S_WRITE;
          else if (instr[7:4] == OP_HLT) state_next = S_HALT;
          else                           state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_FETCH;
        read_req   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD) ||
                     (op == OP_AND) || (op == OP_XOR);
      end
      S_WRITE: begin
        state_next = S_FETCH;
        write_req  = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Enables are masked by rst so a reset landing on WRITE never corrupts the file
  assign rf_read_en    = read_req & ~rst;
  assign rf_write_en   = write_req & ~rst;
  assign bus_drive     = write_req & ~rst;
  assign bus           = bus_drive ? acc : 'z;
  assign rf_read_addr  = ir[3:0];
  assign rf_write_addr = ir[3:0];
  assign halted        = (state == S_HALT);

  assign sum  = {1'b0, acc} + {1'b0, bus};
  assign diff = {1'b0, acc} - {1'b0, bus};

  // Accumulator/flag update applied at the closing edge of EXEC
  always_comb begin
    acc_next   = acc;
    carry_next = carry;
    zero_next  = zero;
    case (op)
      OP_ADD: begin
        acc_next   = sum[7:0];
        carry_next = sum[8];
        zero_next  = (sum[7:0] == '0);
      end
      OP_SUB: begin
        acc_next   = diff[7:0];
        carry_next = diff[8];
        zero_next  = (diff[7:0] == '0);
      end
      OP_LD: begin
        acc_next  = bus;
        zero_next = (bus == '0);
      end
      OP_AND: begin
        acc_next  = acc & bus;
        zero_next = ((acc & bus) == '0);
      end
      OP_XOR: begin
        acc_next  = acc ^ bus;
        zero_next = ((acc ^ bus) == '0);
      end
      OP_LDI: begin
        acc_next  = {4'b0000, ir[3:0]};
        zero_next = (ir[3:0] == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && instr_valid) ir <= instr;
      if (state == S_EXEC) begin
        acc   <= acc_next;
        carry <= carry_next;
        zero  <= zero_next;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench: directed scenarios plus random instruction stream against
// an arithmetic reference model, with a behavioural 16x8 register file on the bus.
module tb_accumulator_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready;
  logic [3:0] rf_read_addr, rf_write_addr;
  logic       rf_read_en, rf_write_en;
  wire  [7:0] bus;
  logic [7:0] acc;
  logic       carry, zero, halted;

  int total = 0;
  int bad   = 0;

  accumulator_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .rf_read_addr (rf_read_addr),
    .rf_read_en   (rf_read_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_en  (rf_write_en),
    .bus          (bus),
    .acc          (acc),
    .carry        (carry),
    .zero         (zero),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Register file: power-up contents Ri=i
  logic [7:0] rf [16];
  logic       rf_load = 1'b1;
  assign bus = rf_read_en ? rf[rf_read_addr] : 'z;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
    end else if (rf_write_en) begin
      rf[rf_write_addr] <= bus;
    end
  end

  // Reference model
  int m_acc, m_carry, m_zero, m_halt;
  int m_rf [16];

  task automatic model_reset();
    m_acc = 0; m_carry = 0; m_zero = 0; m_halt = 0;
  endtask

  task automatic model_apply(input logic [7:0] ins);
    int op, idx, r, s;
    op  = int'(ins[7:4]);
    idx = int'(ins[3:0]);
    r   = m_rf[idx];
    case (op)
      1: begin s = m_acc + r; m_carry = (s > 255) ? 1 : 0; m_acc = s % 256; end
      2: begin m_carry = (m_acc < r) ? 1 : 0; m_acc = (m_acc - r + 256) % 256; end
      3: m_rf[idx] = m_acc;
      4: m_acc = r;
      5: m_acc = m_acc & r;
      6: m_acc = m_acc ^ r;
      7: m_acc = idx;
      15: m_halt = 1;
      default: ;
    endcase
    if (op == 1 || op == 2 || op == 4 || op == 5 || op == 6 || op == 7)
      m_zero = (m_acc == 0) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_acc"}, {1'b0, acc}, 9'(m_acc));
    chk({tag, "_carry"}, {8'b0, carry}, 9'(m_carry));
    chk({tag, "_zero"}, {8'b0, zero}, 9'(m_zero));
    chk({tag, "_halted"}, {8'b0, halted}, 9'(m_halt));
  endtask

  // Issue one instruction from FETCH; optionally keep valid high through the
  // following cycle with a scrambled instr that must be ignored.
  task automatic do_instr(input logic [7:0] ins, input bit hold);
    logic [3:0] op;
    bit         exp_ren;
    op = ins[7:4];
    exp_ren = (op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    chk("ready_fetch", {8'b0, instr_ready}, 9'd1);
    chk("ren_fetch", {8'b0, rf_read_en}, 9'd0);
    chk("wen_fetch", {8'b0, rf_write_en}, 9'd0);
    @(negedge clk);
    chk("ready_busy", {8'b0, instr_ready}, 9'd0);
    chk("ren_busy", {8'b0, rf_read_en}, {8'b0, exp_ren});
    if (exp_ren) chk("raddr", {5'b0, rf_read_addr}, {5'b0, ins[3:0]});
    chk("wen_busy", {8'b0, rf_write_en}, {8'b0, op == 4'h3});
    if (op == 4'h3) begin
      chk("waddr", {5'b0, rf_write_addr}, {5'b0, ins[3:0]});
      chk("bus_wr", {1'b0, bus}, 9'(m_acc));
    end
    instr = 8'($urandom);
    instr_valid = hold;
    model_apply(ins);
    @(posedge clk);
    #1;
    chk_arch("post");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = i;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_load = 1'b0;
    rst = 1'b0;
    #1;
    chk_arch("reset");
    chk("reset_ready", {8'b0, instr_ready}, 9'd1);
    chk("reset_ren", {8'b0, rf_read_en}, 9'd0);
    chk("reset_wen", {8'b0, rf_write_en}, 9'd0);

    // Arithmetic: LDI 5, ADD R3 -> 0x08
    do_instr(8'h75, 1'b0);
    do_instr(8'h13, 1'b0);
    chk("add_acc", {1'b0, acc}, 9'h008);

    // Borrow and zero
    do_instr(8'h72, 1'b0);
    do_instr(8'h25, 1'b0);
    chk("sub_acc", {1'b0, acc}, 9'h0FD);
    chk("sub_borrow", {8'b0, carry}, 9'd1);
    do_instr(8'h40, 1'b0);
    chk("ld0_zero", {8'b0, zero}, 9'd1);
    chk("ld0_carry", {8'b0, carry}, 9'd1);

    // Writeback, back-to-back with valid held high
    do_instr(8'h79, 1'b1);
    do_instr(8'h3C, 1'b1);
    do_instr(8'h4C, 1'b1);
    chk("mov_ld_acc", {1'b0, acc}, 9'h009);
    chk("rf12", {1'b0, rf[12]}, 9'h009);

    // Idle cycles
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", {8'b0, instr_ready}, 9'd1);
      chk("idle_acc", {1'b0, acc}, 9'(m_acc));
    end

    // Reset mid-write: LDI 7, MOV R4 with rst during WRITE
    do_instr(8'h77, 1'b0);
    @(negedge clk);
    instr = 8'h34;
    instr_valid = 1'b1;
    chk("mw_ready", {8'b0, instr_ready}, 9'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mw_wen", {8'b0, rf_write_en}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk_arch("mw_reset");
    chk("mw_rf4", {1'b0, rf[4]}, 9'(m_rf[4]));
    do_instr(8'h44, 1'b0);
    chk("mw_ld4", {1'b0, acc}, 9'h004);

    // Random stream, no HLT
    for (int n = 0; n < 150; n++) begin
      logic [7:0] ins;
      ins = {4'($urandom_range(0, 14)), 4'($urandom)};
      do_instr(ins, 1'($urandom));
      if (($urandom % 8) == 0) begin
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rnd_idle_ready", {8'b0, instr_ready}, 9'd1);
      end
    end
    for (int i = 0; i < 16; i++) chk("rnd_rf", {1'b0, rf[i]}, 9'(m_rf[i]));

    // Halt
    do_instr(8'hF0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      instr = 8'($urandom);
      instr_valid = 1'b1;
      chk("halt_halted", {8'b0, halted}, 9'd1);
      chk("halt_ready", {8'b0, instr_ready}, 9'd0);
      chk("halt_acc", {1'b0, acc}, 9'(m_acc));
      chk("halt_ren", {8'b0, rf_read_en}, 9'd0);
      chk("halt_wen", {8'b0, rf_write_en}, 9'd0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk_arch("halt_reset");
    chk("halt_reset_ready", {8'b0, instr_ready}, 9'd1);
    do_instr(8'h7A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

Multi-cycle control stage that sits directly upstream of the 16×8 register file on the shared 8-bit bus. It accepts 8-bit instructions over a valid/ready handshake and drives the register file's read/write address and enable lines. It executes each instruction against an internal 8-bit accumulator, and drives the bus itself only when writing the accumulator back into a register.

## Interface
Parameters: none; fixed 8-bit data, 4-bit register address.

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction word present
- instr  in  8  [7:4] opcode, [3:0] operand (register index or immediate)
- instr_ready  out  1  sequencer can accept an instruction this cycle
- rf_read_addr  out  4  register file read address
- rf_read_en  out  1  register file drives bus
- rf_write_addr  out  4  register file write address
- rf_write_en  out  1  register file captures bus at posedge
- bus  inout  8  shared data bus; driven by this block only during WRITE, else high-Z
- acc  out  8  accumulator
- carry  out  1  carry/borrow flag
- zero  out  1  zero flag
- halted  out  1  HLT executed

## Operation
- States: FETCH, EXEC, WRITE, HALT.
- FETCH: instr_ready=1. On instr_valid, latch instr into ir. Go to WRITE if opcode=MOV, HALT if HLT, else EXEC. Without instr_valid, stay in FETCH.
- EXEC: go to FETCH.
- WRITE: go to FETCH.
- HALT: stays in HALT until rst.
- Opcodes (op, effect):
  - 0x0 NOP: no effect.
  - 0x1 ADD Ri: {carry,acc}=acc+Ri, 9-bit sum.
  - 0x2 SUB Ri: acc=acc−Ri mod 256; carry=1 iff acc<Ri before the operation (borrow).
  - 0x3 MOV Ri: Ri=acc.
  - 0x4 LD Ri: acc=Ri.
  - 0x5 AND Ri: acc=acc&Ri.
  - 0x6 XOR Ri: acc=acc^Ri.
  - 0x7 LDI imm: acc={4'b0,imm}.
  - 0xF HLT.
  - 0x8–0xE are reserved and execute as NOP via EXEC.
- ADD/SUB/LD/AND/XOR in EXEC:
  - rf_read_en=1 and rf_read_addr=ir[3:0], combinational from state.
  - bus value captured into acc at the closing edge.
- zero updates on ADD, SUB, LD, AND, XOR and LDI; it is set iff the new acc==0.
- carry updates only on ADD and SUB; all other ops leave it unchanged.
- MOV in WRITE: bus=acc, rf_write_en=1, rf_write_addr=ir[3:0].
- Bus contention rule: rf_read_en and the bus driver are never active in the same cycle.
- rf_read_en=0 in FETCH, WRITE and HALT.
- rf_write_en=0 outside WRITE.
- halted=1 iff state=HALT. instr_ready=0 in EXEC, WRITE and HALT.

## Timing
- Reset (rst high at posedge):
  - state=FETCH, acc=0x00, carry=0, zero=0, ir=0x00, halted=0.
  - In the cycle after the reset edge: instr_ready=1, enables 0, bus high-Z.
- rst overrides every state, including HALT.
- rf_write_en, rf_read_en and the bus driver are gated with ~rst. A reset asserted during WRITE suppresses that write, and the register is left unchanged.
- Throughput and latency:
  - Every non-HLT instruction takes exactly 2 cycles: accept cycle plus EXEC/WRITE.
  - Maximum rate is one instruction per 2 cycles.
  - acc and flags are valid in the cycle after the EXEC edge.
  - A MOV's register update is visible to a LD issued in the immediately following accept cycle.
- Handshake:
  - Transfer occurs only at posedge with instr_valid&instr_ready.
  - instr is sampled only at the transfer edge.
  - The source must hold instr/instr_valid while instr_ready=0; changes during that time are ignored.
- Address outputs: rf_read_addr and rf_write_addr are ir[3:0] in all states. Only the enables qualify them.

## Test plan
Bench uses the team register file, power-up contents Ri=i.
- Arithmetic: LDI 5 (0x75), ADD R3 (0x13).
  - acc=0x08, carry=0, zero=0.
  - rf_read_en high for exactly one cycle, with rf_read_addr=3.
- Borrow and zero: LDI 2 (0x72), SUB R5 (0x25) → acc=0xFD, carry=1. Then LD R0 (0x40) → acc=0x00, zero=1, carry still 1.
- Writeback: LDI 9 (0x79), MOV R12 (0x3C), LD R12 (0x4C) → acc=0x09.
  - rf_write_en high for exactly one cycle, with bus=0x09.
  - bus high-Z in all other cycles.
- Handshake:
  - Hold instr_valid high continuously → instr_ready toggles 1,0,1,0 and each instruction is taken once.
  - Insert 3 idle cycles → sequencer stays in FETCH with acc unchanged.
  - Change instr during EXEC → the change is ignored.
- Halt: HLT (0xF0).
  - halted=1 and instr_ready=0 for 10+ cycles while instr_valid=1; acc frozen.
  - Pulse rst → acc=0x00, halted=0, instr_ready=1.
- Reset mid-write: LDI 7, MOV R4, with rst high during the WRITE cycle → R4 stays 0x04 and no bus drive occurs. After reset, LD R4 gives acc=0x04.
